// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DEF_DATA_W / DEF_ADDR_W  : default write data / register address widths
//   DEF_STARVE_LIMIT         : default consecutive-denial limit before a stall request
//   wb_src_e                 : which requester owns the write port in a cycle
package reg_wb_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MDU,
    SRC_FPU
  } wb_src_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bus bundle between MEM/WB, the long-latency units, decode and the register
// file write port.
//   slave  : the arbiter (takes requests, drives Ready, Rd_Busy, stall and write port)
//   master : the surrounding pipeline / testbench
interface reg_wb_arbiter_if #(
  parameter int ADDR_W = reg_wb_pkg::DEF_ADDR_W,
  parameter int DATA_W = reg_wb_pkg::DEF_DATA_W
) ();

  logic              MEM_WB_Freeze;
  logic              Pipe_WB_Valid;
  logic [ADDR_W-1:0] Pipe_WB_Addr;
  logic [DATA_W-1:0] Pipe_WB_Data;
  logic              Pipe_WB_IRQ;
  logic              MDU_Valid;
  logic [ADDR_W-1:0] MDU_Addr;
  logic [DATA_W-1:0] MDU_Data;
  logic              MDU_IRQ;
  logic              MDU_Ready;
  logic              FPU_Valid;
  logic [ADDR_W-1:0] FPU_Addr;
  logic [DATA_W-1:0] FPU_Data;
  logic              FPU_IRQ;
  logic              FPU_Ready;
  logic              LL_Issue_Valid;
  logic [ADDR_W-1:0] LL_Issue_Addr;
  logic [31:0]       Rd_Busy;
  logic              Pipe_Stall_Req;
  logic [ADDR_W-1:0] RD_Write_Addr;
  logic [DATA_W-1:0] RD_Write_Data;
  logic              Reg_Write_Enable;
  logic              WB_Ctrl__IRQ;

  modport slave (
    input  MEM_WB_Freeze,
    input  Pipe_WB_Valid, Pipe_WB_Addr, Pipe_WB_Data, Pipe_WB_IRQ,
    input  MDU_Valid, MDU_Addr, MDU_Data, MDU_IRQ,
    output MDU_Ready,
    input  FPU_Valid, FPU_Addr, FPU_Data, FPU_IRQ,
    output FPU_Ready,
    input  LL_Issue_Valid, LL_Issue_Addr,
    output Rd_Busy, Pipe_Stall_Req,
    output RD_Write_Addr, RD_Write_Data, Reg_Write_Enable, WB_Ctrl__IRQ
  );

  modport master (
    output MEM_WB_Freeze,
    output Pipe_WB_Valid, Pipe_WB_Addr, Pipe_WB_Data, Pipe_WB_IRQ,
    output MDU_Valid, MDU_Addr, MDU_Data, MDU_IRQ,
    input  MDU_Ready,
    output FPU_Valid, FPU_Addr, FPU_Data, FPU_IRQ,
    input  FPU_Ready,
    output LL_Issue_Valid, LL_Issue_Addr,
    input  Rd_Busy, Pipe_Stall_Req,
    input  RD_Write_Addr, RD_Write_Data, Reg_Write_Enable, WB_Ctrl__IRQ
  );

endinterface

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset (pointer prefers req[0])
//   req      : request vector, bit 0 = MDU, bit 1 = FPU
//   en       : arbitration allowed this cycle; no grant when low
//   gnt      : one-hot (or zero) grant, combinational from req/en/pointer
// The pointer only moves after an actual grant, to the requester not granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q;  // 0: req[0] preferred, 1: req[1] preferred

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst)       ptr_q <= 1'b0;
    else if (|gnt) ptr_q <= gnt[0];
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback has fixed priority,
// MDU and FPU results share the remaining slots round-robin. Also tracks
// pending long-latency destinations (Rd_Busy) and requests a pipeline bubble
// when a long-latency result has been denied STARVE_LIMIT cycles in a row.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : reg_wb_arbiter_if.slave (requests, Ready, scoreboard, write port)
//   Perf_Conflict_Cnt / Perf_Stall_Cnt : only with REG_WB_PERF_EN defined
// Optional feature macro: REG_WB_PERF_EN
module reg_wb_arbiter #(
  parameter int DATA_W       = reg_wb_pkg::DEF_DATA_W,
  parameter int ADDR_W       = reg_wb_pkg::DEF_ADDR_W,
  parameter int STARVE_LIMIT = reg_wb_pkg::DEF_STARVE_LIMIT  // 1..15
) (
  input  logic                CLK,
  input  logic                RST,
  reg_wb_arbiter_if.slave     bus
`ifdef REG_WB_PERF_EN
  ,
  output logic [31:0]         Perf_Conflict_Cnt,
  output logic [31:0]         Perf_Stall_Cnt
`endif
);

  import reg_wb_pkg::*;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              run, pipe_req, ll_pend, ll_grant;
  logic [1:0]        ll_gnt;
  wb_src_e           win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_irq;
  logic [3:0]        starve_q, starve_d;
  logic              stall_q;
  logic [31:0]       busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              irq_q, we_q;

  // No grants in reset (in-flight requests are dropped) or while frozen.
  assign run      = !RST && !bus.MEM_WB_Freeze;
  assign pipe_req = bus.Pipe_WB_Valid && (bus.Pipe_WB_Addr != '0);
  assign ll_pend  = bus.MDU_Valid || bus.FPU_Valid;
  assign ll_grant = |ll_gnt;

  rr_arb2 u_rr (
    .clk (CLK),
    .rst (RST),
    .req ({bus.FPU_Valid, bus.MDU_Valid}),
    .en  (run && !pipe_req),
    .gnt (ll_gnt)
  );

  assign bus.MDU_Ready = ll_gnt[0];
  assign bus.FPU_Ready = ll_gnt[1];

  always_comb begin
    win = SRC_NONE;
    if (run) begin
      if (pipe_req)       win = SRC_PIPE;
      else if (ll_gnt[0]) win = SRC_MDU;
      else if (ll_gnt[1]) win = SRC_FPU;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_irq  = 1'b0;
    unique case (win)
      SRC_PIPE: begin sel_addr = bus.Pipe_WB_Addr; sel_data = bus.Pipe_WB_Data; sel_irq = bus.Pipe_WB_IRQ; end
      SRC_MDU:  begin sel_addr = bus.MDU_Addr;     sel_data = bus.MDU_Data;     sel_irq = bus.MDU_IRQ;     end
      SRC_FPU:  begin sel_addr = bus.FPU_Addr;     sel_data = bus.FPU_Data;     sel_irq = bus.FPU_IRQ;     end
      default: ;
    endcase
  end

  // Starvation: counts consecutive cycles a pending long-latency result lost
  // to the pipeline; saturates at LIMIT so the stall request stays up.
  always_comb begin
    starve_d = starve_q;
    if (ll_grant || !ll_pend)                    starve_d = 4'd0;
    else if (win == SRC_PIPE && starve_q < LIMIT) starve_d = starve_q + 4'd1;
  end

  // Scoreboard: clear on grant first, then set on issue so a same-cycle
  // issue of the same rd wins. Register x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (ll_grant) busy_d[sel_addr] = 1'b0;
    if (bus.LL_Issue_Valid && bus.LL_Issue_Addr != '0) busy_d[bus.LL_Issue_Addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      irq_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      // Issue tracking continues during freeze; no grant can clear then.
      busy_q <= busy_d;
      if (!bus.MEM_WB_Freeze) begin
        // Long-latency grants to x0 are consumed without a write.
        we_q     <= (win != SRC_NONE) && (sel_addr != '0);
        starve_q <= starve_d;
        stall_q  <= (starve_d == LIMIT);
        if (win != SRC_NONE) begin
          addr_q <= sel_addr;
          data_q <= sel_data;
          irq_q  <= sel_irq;
        end
      end
    end
  end

  assign bus.Rd_Busy          = busy_q;
  assign bus.Pipe_Stall_Req   = stall_q;
  assign bus.RD_Write_Addr    = addr_q;
  assign bus.RD_Write_Data    = data_q;
  assign bus.WB_Ctrl__IRQ     = irq_q;
  assign bus.Reg_Write_Enable = we_q;

`ifdef REG_WB_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      Perf_Conflict_Cnt <= '0;
      Perf_Stall_Cnt    <= '0;
    end else begin
      if (win == SRC_PIPE && ll_pend && Perf_Conflict_Cnt != '1)
        Perf_Conflict_Cnt <= Perf_Conflict_Cnt + 32'd1;
      if (!bus.MEM_WB_Freeze && starve_d == LIMIT && !stall_q && Perf_Stall_Cnt != '1)
        Perf_Stall_Cnt <= Perf_Stall_Cnt + 32'd1;
    end
  end
`endif

endmodule
